// File: rtl/param_queue.sv
// ============================================================================
// Module   : param_queue
// Brief    : Synchronous FIFO with wrap-bit pointers, registered read data and
//            level flags. Optional macro QUEUE_ERR_FLAGS_EN adds sticky
//            overflow/underflow outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_queue #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
`ifdef QUEUE_ERR_FLAGS_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output logic [ADDR_W:0]   count
);

  localparam int             c_DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W:0] c_AF_LVL = AF_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0] c_AE_LVL = AE_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0] c_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [ADDR_W:0]   r_head;
  logic [ADDR_W:0]   r_tail;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_dout;

  logic w_empty;
  logic w_full;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_empty = (r_head == r_tail);
  assign w_full  = (r_head[ADDR_W-1:0] == r_tail[ADDR_W-1:0]) &&
                   (r_head[ADDR_W] != r_tail[ADDR_W]);

  // When full, a concurrent read frees the slot the write is about to fill.
  assign w_wr_acc = wr_en && (!w_full || rd_en);
  assign w_rd_acc = rd_en && !w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc && !rst) begin
      r_mem[r_tail[ADDR_W-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_dout  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_tail <= r_tail + c_ONE;
      end
      if (w_rd_acc) begin
        r_head <= r_head + c_ONE;
        r_dout <= r_mem[r_head[ADDR_W-1:0]];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef QUEUE_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full && !rd_en) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  assign dout         = r_dout;
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = r_count;
  assign almost_full  = (r_count >= c_AF_LVL);
  assign almost_empty = (r_count <= c_AE_LVL);

endmodule

`default_nettype wire

// File: tb/tb_param_queue.sv
// ============================================================================
// Module   : tb_param_queue
// Brief    : Directed self-checking bench for param_queue (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_queue;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
`ifdef QUEUE_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int n_checks = 0;
  int n_errors = 0;

  param_queue dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`ifdef QUEUE_ERR_FLAGS_EN
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle 1ns before checks.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    #1;
    // Reset with write request asserted: reset wins.
    step(1'b1, 1'b0, 8'hEE);
    step(1'b1, 1'b0, 8'hEE);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_dout", dout, 0);
`ifdef QUEUE_ERR_FLAGS_EN
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
`endif
    rst = 1'b0;

    // Fill with 0x10..0x17.
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, 8'h10 + 8'(k - 1));
      chk($sformatf("fill_count%0d", k), count, k);
      chk($sformatf("fill_af%0d", k), almost_full, (k >= 6));
      chk($sformatf("fill_ae%0d", k), almost_empty, (k <= 2));
      chk($sformatf("fill_full%0d", k), full, (k == 8));
      chk($sformatf("fill_empty%0d", k), empty, 0);
    end
    step(1'b1, 1'b0, 8'h99);
    chk("ovf_write_count", count, 8);
    chk("ovf_write_full", full, 1);

    // Drain; the dropped 0x99 must not appear.
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 8'h00);
      chk($sformatf("drain_dout%0d", k), dout, 8'h10 + k);
      chk($sformatf("drain_count%0d", k), count, 7 - k);
    end
    chk("drain_empty", empty, 1);
    chk("drain_ae", almost_empty, 1);
    step(1'b0, 1'b1, 8'h00);
    chk("unf_read_dout", dout, 8'h17);
    chk("unf_read_count", count, 0);
    chk("unf_read_empty", empty, 1);

    // Wrap-around: pointers start at 8, end at 8+5+6 = 19 (mod 16 = 3).
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 8'h20 + 8'(k));
    chk("wrap_count5", count, 5);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 8'h00);
      chk($sformatf("wrap_a%0d", k), dout, 8'h20 + k);
    end
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 8'h30 + 8'(k));
    chk("wrap_count6", count, 6);
    chk("wrap_af6", almost_full, 1);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 8'h00);
      chk($sformatf("wrap_b%0d", k), dout, 8'h30 + k);
    end
    chk("wrap_empty", empty, 1);

    // Full with simultaneous read and write.
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 8'h40 + 8'(k));
    chk("full2_full", full, 1);
    step(1'b1, 1'b1, 8'hAA);
    chk("full_rw_dout", dout, 8'h40);
    chk("full_rw_full", full, 1);
    chk("full_rw_count", count, 8);
    for (int k = 1; k < 8; k++) begin
      step(1'b0, 1'b1, 8'h00);
      chk($sformatf("full_rw_drain%0d", k), dout, 8'h40 + k);
    end
    step(1'b0, 1'b1, 8'h00);
    chk("full_rw_last", dout, 8'hAA);
    chk("full_rw_empty", empty, 1);

    // Empty with simultaneous read and write: write only, no bypass.
    step(1'b1, 1'b1, 8'h55);
    chk("empty_rw_count", count, 1);
    chk("empty_rw_empty", empty, 0);
    chk("empty_rw_dout", dout, 8'hAA);
    step(1'b0, 1'b1, 8'h00);
    chk("empty_rw_read", dout, 8'h55);
    chk("empty_rw_count0", count, 0);

    // Mid-operation reset with a write pending.
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'h60 + 8'(k));
    chk("mid_count4", count, 4);
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h77);
    rst = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_dout", dout, 0);
    step(1'b0, 1'b1, 8'h00);
    chk("mid_rst_read_dout", dout, 0);
    chk("mid_rst_read_count", count, 0);

`ifdef QUEUE_ERR_FLAGS_EN
    rst = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    chk("flag_clr_ovf", overflow, 0);
    chk("flag_clr_unf", underflow, 0);
    step(1'b0, 1'b1, 8'h00);
    chk("flag_unf_set", underflow, 1);
    chk("flag_unf_ovf0", overflow, 0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 8'h80 + 8'(k));
    chk("flag_full_ovf0", overflow, 0);
    step(1'b1, 1'b1, 8'h90);
    chk("flag_rw_ovf0", overflow, 0);
    step(1'b1, 1'b0, 8'h91);
    chk("flag_ovf_set", overflow, 1);
    step(1'b0, 1'b1, 8'h00);
    chk("flag_ovf_sticky", overflow, 1);
    chk("flag_unf_sticky", underflow, 1);
    rst = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    chk("flag_rst_ovf", overflow, 0);
    chk("flag_rst_unf", underflow, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/param_queue.md
PARAM_QUEUE -- requirements
Module: param_queue

Interface
REQ-001 Parameter: DATA_W, default 8, data width in bits; legal range 1..64.
REQ-002 Parameter: ADDR_W, default 3, address width; DEPTH = 2**ADDR_W entries; legal range 1..10.
REQ-003 Parameter: AF_LVL, default 6, almost_full threshold in entries; legal range 1..DEPTH-1.
REQ-004 Parameter: AE_LVL, default 2, almost_empty threshold in entries; legal range 1..DEPTH-1.
REQ-005 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-006 Port: rst  in  1  synchronous, active-high reset.
REQ-007 Port: wr_en  in  1  write request.
REQ-008 Port: din  in  DATA_W  write data.
REQ-009 Port: rd_en  in  1  read request.
REQ-010 Port: dout  out  DATA_W  registered read data.
REQ-011 Port: full  out  1  high when count == DEPTH.
REQ-012 Port: empty  out  1  high when count == 0.
REQ-013 Port: almost_full  out  1  high when count >= AF_LVL.
REQ-014 Port: almost_empty  out  1  high when count <= AE_LVL.
REQ-015 Port: count  out  ADDR_W+1  number of stored entries, 0..DEPTH.
REQ-016 Port (QUEUE_ERR_FLAGS_EN only): overflow  out  1  sticky flag, rejected write.
REQ-017 Port (QUEUE_ERR_FLAGS_EN only): underflow  out  1  sticky flag, rejected read.

Function
REQ-018 Storage: DEPTH x DATA_W register array; all DEPTH entries usable, with no sacrificed slot.
REQ-019 Pointers: head (read) and tail (write) are ADDR_W+1 bits; the low ADDR_W bits address the array; the MSB is the wrap bit.
- Pointer increments wrap modulo 2**(ADDR_W+1).
- empty = (head == tail).
- full = (low bits equal) and (MSBs differ).
REQ-020 A write is accepted when wr_en=1 and (full=0, or rd_en=1 with full=1).
- On acceptance: mem[tail] <= din and tail <= tail+1.
REQ-021 A read is accepted when rd_en=1 and empty=0.
- On acceptance: dout <= mem[head] and head <= head+1.
- Latency: data is visible on dout one cycle after the accepting edge.
REQ-022 dout holds its last value when no read is accepted.
REQ-023 Simultaneous read and write, not empty and not full: both are accepted and count is unchanged.
REQ-024 Simultaneous read and write when full: both are accepted; the read returns the oldest entry, the new entry fills the freed slot, and full stays 1.
REQ-025 Simultaneous read and write when empty: only the write is accepted; no bypass to dout; on the next cycle empty=0 and count=1.
REQ-026 A write while full without rd_en is dropped; the array, tail and count are unchanged.
REQ-027 A read while empty is ignored; head, count and dout are unchanged.
REQ-028 count <= count + accepted_write - accepted_read, registered.
- All flags are decoded combinationally from the registered pointers and count, so flags are valid in the same cycle as count.

Reset
REQ-029 While rst=1 at a rising edge:
- head, tail and count become 0; dout becomes 0.
- empty=1, full=0, almost_empty=1, almost_full=0.
- overflow and underflow become 0.
REQ-030 rst has priority over wr_en and rd_en in the same cycle; a reset mid-operation discards all stored entries.
REQ-031 Array contents are not reset; they are unobservable until rewritten.

Configuration
REQ-032 Macro QUEUE_ERR_FLAGS_EN, when defined, adds the overflow and underflow ports.
- overflow sets to 1 on the edge after a write is dropped per REQ-026.
- underflow sets to 1 on the edge after a read is ignored per REQ-027.
- Both flags stay set until rst.
REQ-033 Without QUEUE_ERR_FLAGS_EN, neither port nor its logic exists; all other behaviour is identical.

Verification
REQ-034 Default parameters: reset, then write 8 words 0x10..0x17 -> full=1, count=8, almost_full=1 after the 6th write; a 9th write leaves count=8.
REQ-035 Read 8 times -> dout sequence 0x10..0x17, each value one cycle after its rd_en; empty=1 and count=0 at the end; a 9th read leaves dout=0x17.
REQ-036 Wrap-around: 5 writes, then 5 reads, then 6 writes and 6 reads -> order preserved across the pointer wrap; the pointer MSB toggles.
REQ-037 Full with wr_en=rd_en=1 and din=0xAA -> dout=oldest entry, full stays 1, 0xAA is read last; empty with both asserted -> count=1, dout unchanged.
REQ-038 Assert rst with count=4 and wr_en=1 -> next cycle count=0, empty=1, dout=0.
REQ-039 With QUEUE_ERR_FLAGS_EN: write while full -> overflow=1 and stays 1; read while empty -> underflow=1; rst -> both 0.
